// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-access stage: aluop codes, exception codes, bus widths.
// Also provides the decode helper used by the lane aligner.
package mem_access_pkg;

    localparam int unsigned DataW    = 32;
    localparam int unsigned AddrW    = 32;
    localparam int unsigned RegAddrW = 5;
    localparam int unsigned AluOpW   = 8;
    localparam int unsigned SelW     = 4;
    localparam int unsigned ExcCodeW = 5;

    localparam logic [AluOpW-1:0] AluOpNop = 8'h00;
    localparam logic [AluOpW-1:0] AluOpAdd = 8'h20;
    localparam logic [AluOpW-1:0] AluOpLb  = 8'hE0;
    localparam logic [AluOpW-1:0] AluOpLh  = 8'hE1;
    localparam logic [AluOpW-1:0] AluOpLw  = 8'hE3;
    localparam logic [AluOpW-1:0] AluOpLbu = 8'hE4;
    localparam logic [AluOpW-1:0] AluOpLhu = 8'hE5;
    localparam logic [AluOpW-1:0] AluOpSb  = 8'hE8;
    localparam logic [AluOpW-1:0] AluOpSh  = 8'hE9;
    localparam logic [AluOpW-1:0] AluOpSw  = 8'hEB;

    localparam logic [ExcCodeW-1:0] ExcAdEL = 5'd4;
    localparam logic [ExcCodeW-1:0] ExcAdES = 5'd5;

    typedef enum logic [1:0] {
        SizeByte,
        SizeHalf,
        SizeWord
    } mem_size_e;

    typedef struct packed {
        logic      is_mem;
        logic      is_load;
        logic      sign_ext;
        mem_size_e size;
    } mem_op_t;

    function automatic mem_op_t decode_op(input logic [AluOpW-1:0] aluop);
        mem_op_t op;
        op = '{is_mem: 1'b0, is_load: 1'b0, sign_ext: 1'b0, size: SizeWord};
        case (aluop)
            AluOpLb:  op = '{is_mem: 1'b1, is_load: 1'b1, sign_ext: 1'b1, size: SizeByte};
            AluOpLbu: op = '{is_mem: 1'b1, is_load: 1'b1, sign_ext: 1'b0, size: SizeByte};
            AluOpLh:  op = '{is_mem: 1'b1, is_load: 1'b1, sign_ext: 1'b1, size: SizeHalf};
            AluOpLhu: op = '{is_mem: 1'b1, is_load: 1'b1, sign_ext: 1'b0, size: SizeHalf};
            AluOpLw:  op = '{is_mem: 1'b1, is_load: 1'b1, sign_ext: 1'b0, size: SizeWord};
            AluOpSb:  op = '{is_mem: 1'b1, is_load: 1'b0, sign_ext: 1'b0, size: SizeByte};
            AluOpSh:  op = '{is_mem: 1'b1, is_load: 1'b0, sign_ext: 1'b0, size: SizeHalf};
            AluOpSw:  op = '{is_mem: 1'b1, is_load: 1'b0, sign_ext: 1'b0, size: SizeWord};
            default:  ;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mem_access_lane_align.sv
// mem_lane_align: combinational byte-lane select, store replication and load extension.
// Flags misaligned half/word accesses; the caller decides whether that matters.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [AluOpW-1:0] aluop,
    input  logic [1:0]        offset,
    input  logic [DataW-1:0]  reg2,
    input  logic [DataW-1:0]  rdata,
    output logic              is_mem,
    output logic              is_load,
    output logic              misaligned,
    output logic [SelW-1:0]   sel,
    output logic [DataW-1:0]  wdata,
    output logic [DataW-1:0]  load_data
);

    mem_op_t    op;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        op         = decode_op(aluop);
        is_mem     = op.is_mem;
        is_load    = op.is_load;
        sel        = '0;
        wdata      = '0;
        load_data  = '0;
        misaligned = 1'b0;

        case (offset)
            2'd0:    rd_byte = rdata[7:0];
            2'd1:    rd_byte = rdata[15:8];
            2'd2:    rd_byte = rdata[23:16];
            default: rd_byte = rdata[31:24];
        endcase
        // Half lane follows addr[1] only; addr[0] is dropped when misaligned.
        rd_half = offset[1] ? rdata[31:16] : rdata[15:0];

        if (op.is_mem) begin
            case (op.size)
                SizeByte: begin
                    sel       = 4'b0001 << offset;
                    wdata     = {4{reg2[7:0]}};
                    load_data = {{24{op.sign_ext & rd_byte[7]}}, rd_byte};
                end
                SizeHalf: begin
                    sel        = offset[1] ? 4'b1100 : 4'b0011;
                    wdata      = {2{reg2[15:0]}};
                    load_data  = {{16{op.sign_ext & rd_half[15]}}, rd_half};
                    misaligned = offset[0];
                end
                default: begin
                    sel        = 4'b1111;
                    wdata      = reg2;
                    load_data  = rdata;
                    misaligned = |offset;
                end
            endcase
            if (op.is_load) begin
                wdata = '0;
            end
        end
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: IDLE/REQ/DONE bus handshake FSM with writeback register.
// Define MEM_ALIGN_CHECK_EN to raise AdEL/AdES on misaligned half/word accesses.
module mem_access
    import mem_access_pkg::*;
(
    input  logic                clk,
    input  logic                rst,

    input  logic [RegAddrW-1:0] mem_wd,
    input  logic                mem_wreg,
    input  logic [DataW-1:0]    mem_wdata,
    input  logic [AluOpW-1:0]   mem_aluop,
    input  logic [AddrW-1:0]    mem_mem_addr,
    input  logic [DataW-1:0]    mem_reg2,
    input  logic [AddrW-1:0]    mem_pc,

    output logic [RegAddrW-1:0] wb_wd,
    output logic                wb_wreg,
    output logic [DataW-1:0]    wb_wdata,

    output logic                dbus_req,
    output logic                dbus_we,
    output logic [AddrW-1:0]    dbus_addr,
    output logic [SelW-1:0]     dbus_sel,
    output logic [DataW-1:0]    dbus_wdata,
    input  logic                dbus_ack,
    input  logic [DataW-1:0]    dbus_rdata,

    output logic                stall_req,

    output logic                exc_valid,
    output logic [ExcCodeW-1:0] exc_code,
    output logic [AddrW-1:0]    exc_badvaddr,
    output logic [AddrW-1:0]    exc_pc
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q;
    logic [DataW-1:0] rdata_q;

    logic             is_mem;
    logic             is_load;
    logic             misaligned;
    logic [SelW-1:0]  lane_sel;
    logic [DataW-1:0] lane_wdata;
    logic [DataW-1:0] load_data;
    logic             addr_err;
    logic             start;

    // Pipeline register holds mem_* stable while stalled, so one aligner serves issue and DONE.
    mem_lane_align u_lane (
        .aluop      (mem_aluop),
        .offset     (mem_mem_addr[1:0]),
        .reg2       (mem_reg2),
        .rdata      (rdata_q),
        .is_mem     (is_mem),
        .is_load    (is_load),
        .misaligned (misaligned),
        .sel        (lane_sel),
        .wdata      (lane_wdata),
        .load_data  (load_data)
    );

`ifdef MEM_ALIGN_CHECK_EN
    assign addr_err = is_mem & misaligned;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
    assign addr_err          = 1'b0;
`endif

    assign start     = (state_q == StIdle) && is_mem && !addr_err;
    assign stall_req = rst && (start || (state_q == StReq));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            rdata_q      <= '0;
            wb_wd        <= '0;
            wb_wreg      <= 1'b0;
            wb_wdata     <= '0;
            dbus_req     <= 1'b0;
            dbus_we      <= 1'b0;
            dbus_addr    <= '0;
            dbus_sel     <= '0;
            dbus_wdata   <= '0;
            exc_valid    <= 1'b0;
            exc_code     <= '0;
            exc_badvaddr <= '0;
            exc_pc       <= '0;
        end else begin
            exc_valid    <= 1'b0;
            exc_code     <= '0;
            exc_badvaddr <= '0;
            exc_pc       <= '0;
            case (state_q)
                StIdle: begin
                    if (addr_err) begin
                        exc_valid    <= 1'b1;
                        exc_code     <= is_load ? ExcAdEL : ExcAdES;
                        exc_badvaddr <= mem_mem_addr;
                        exc_pc       <= mem_pc;
                        wb_wd        <= mem_wd;
                        wb_wreg      <= 1'b0;
                        wb_wdata     <= '0;
                    end else if (start) begin
                        dbus_req   <= 1'b1;
                        dbus_we    <= !is_load;
                        dbus_addr  <= {mem_mem_addr[AddrW-1:2], 2'b00};
                        dbus_sel   <= lane_sel;
                        dbus_wdata <= lane_wdata;
                        state_q    <= StReq;
                    end else begin
                        wb_wd    <= mem_wd;
                        wb_wreg  <= mem_wreg;
                        wb_wdata <= mem_wdata;
                    end
                end
                StReq: begin
                    if (dbus_ack) begin
                        rdata_q  <= dbus_rdata;
                        dbus_req <= 1'b0;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    wb_wd    <= mem_wd;
                    wb_wreg  <= is_load && mem_wreg;
                    wb_wdata <= is_load ? load_data : mem_wdata;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: constant vector table, hand sequences, random ops
// checked against an arithmetic lane/extension model.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic [31:0] mem_pc;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic        stall_req;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_badvaddr;
    logic [31:0] exc_pc;

    mem_access dut (
        .clk          (clk),
        .rst          (rst),
        .mem_wd       (mem_wd),
        .mem_wreg     (mem_wreg),
        .mem_wdata    (mem_wdata),
        .mem_aluop    (mem_aluop),
        .mem_mem_addr (mem_mem_addr),
        .mem_reg2     (mem_reg2),
        .mem_pc       (mem_pc),
        .wb_wd        (wb_wd),
        .wb_wreg      (wb_wreg),
        .wb_wdata     (wb_wdata),
        .dbus_req     (dbus_req),
        .dbus_we      (dbus_we),
        .dbus_addr    (dbus_addr),
        .dbus_sel     (dbus_sel),
        .dbus_wdata   (dbus_wdata),
        .dbus_ack     (dbus_ack),
        .dbus_rdata   (dbus_rdata),
        .stall_req    (stall_req),
        .exc_valid    (exc_valid),
        .exc_code     (exc_code),
        .exc_badvaddr (exc_badvaddr),
        .exc_pc       (exc_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on access size and byte offset.
    function automatic int unsigned size_bytes(input logic [7:0] op);
        if (op == AluOpLb || op == AluOpLbu || op == AluOpSb) return 1;
        if (op == AluOpLh || op == AluOpLhu || op == AluOpSh) return 2;
        return 4;
    endfunction

    function automatic bit is_load_op(input logic [7:0] op);
        return op == AluOpLb || op == AluOpLbu || op == AluOpLh || op == AluOpLhu ||
               op == AluOpLw;
    endfunction

    function automatic int unsigned lane_base(input logic [7:0] op, input logic [31:0] addr);
        int unsigned n = size_bytes(op);
        return ((addr % 4) / n) * n;
    endfunction

    function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] addr);
        int unsigned n = size_bytes(op);
        int unsigned m = ((1 << n) - 1) << lane_base(op, addr);
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] reg2);
        if (is_load_op(op)) return 32'h0;
        case (size_bytes(op))
            1:       return (reg2 & 32'hFF) * 32'h0101_0101;
            2:       return (reg2 & 32'hFFFF) * 32'h0001_0001;
            default: return reg2;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        int unsigned n = size_bytes(op);
        logic [31:0] mask;
        logic [31:0] v;
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v = (rdata >> (8 * lane_base(op, addr))) & mask;
        if ((op == AluOpLb || op == AluOpLh) && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic drive_nop();
        mem_aluop    = AluOpNop;
        mem_wd       = 5'd0;
        mem_wreg     = 1'b0;
        mem_wdata    = 32'h0;
        mem_mem_addr = 32'h0;
        mem_reg2     = 32'h0;
        mem_pc       = 32'h0;
    endtask

    task automatic run_alu(input logic [4:0] wd, input logic wreg, input logic [31:0] data);
        mem_aluop    = AluOpAdd;
        mem_wd       = wd;
        mem_wreg     = wreg;
        mem_wdata    = data;
        mem_mem_addr = $urandom;
        mem_reg2     = $urandom;
        mem_pc       = $urandom;
        dbus_ack     = $urandom_range(0, 1);
        #1;
        chk("alu_stall_comb", {31'b0, stall_req}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        dbus_ack = 1'b0;
        chk("alu_wb_wd", {27'b0, wb_wd}, {27'b0, wd});
        chk("alu_wb_wreg", {31'b0, wb_wreg}, {31'b0, wreg});
        chk("alu_wb_wdata", wb_wdata, data);
        chk("alu_stall", {31'b0, stall_req}, 32'h0);
        chk("alu_no_req", {31'b0, dbus_req}, 32'h0);
    endtask

    // Starts and ends just after a falling edge; inputs held for the whole transaction.
    task automatic run_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                           input logic [31:0] rdata, input int waits, input bit ack_early,
                           input logic [3:0] e_sel, input logic [31:0] e_bw,
                           input logic [31:0] e_wb);
        int   stalls = 0;
        logic ld     = is_load_op(op);
        logic [4:0] wd = 5'($urandom_range(1, 31));
        mem_aluop    = op;
        mem_mem_addr = addr;
        mem_reg2     = reg2;
        mem_wd       = wd;
        mem_wreg     = 1'b1;
        mem_wdata    = 32'h5A5A_0000;
        mem_pc       = 32'h0000_1000;
        dbus_ack     = ack_early;
        dbus_rdata   = ~rdata;
        #1;
        if (stall_req) stalls++;
        chk("mem_stall_issue", {31'b0, stall_req}, 32'h1);
        chk("mem_req_not_yet", {31'b0, dbus_req}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("mem_req", {31'b0, dbus_req}, 32'h1);
        chk("mem_addr", dbus_addr, addr & ~32'h3);
        chk("mem_sel", {28'b0, dbus_sel}, {28'b0, e_sel});
        chk("mem_we", {31'b0, dbus_we}, {31'b0, !ld});
        if (!ld) chk("mem_bus_wdata", dbus_wdata, e_bw);
        chk("mem_exc_quiet", {31'b0, exc_valid}, 32'h0);
        for (int i = 0; i < waits; i++) begin
            dbus_ack   = 1'b0;
            dbus_rdata = $urandom;
            if (stall_req) stalls++;
            @(posedge clk);
            @(negedge clk);
            chk("wait_req_held", {31'b0, dbus_req}, 32'h1);
            chk("wait_addr_held", dbus_addr, addr & ~32'h3);
            chk("wait_sel_held", {28'b0, dbus_sel}, {28'b0, e_sel});
        end
        if (stall_req) stalls++;
        dbus_ack   = 1'b1;
        dbus_rdata = rdata;
        @(posedge clk);
        @(negedge clk);
        if (!ack_early) dbus_ack = 1'b0;
        dbus_rdata = ~rdata;
        chk("done_req_low", {31'b0, dbus_req}, 32'h0);
        chk("done_stall_low", {31'b0, stall_req}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        dbus_ack = 1'b0;
        chk("stall_cycles", stalls, 32'(2 + waits));
        chk("wb_wd", {27'b0, wb_wd}, {27'b0, wd});
        chk("wb_wreg", {31'b0, wb_wreg}, {31'b0, ld});
        if (ld) chk("wb_load_data", wb_wdata, e_wb);
        drive_nop();
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] rdata;
        int          waits;
        logic [3:0]  sel;
        logic [31:0] bw;
        logic [31:0] wb;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{AluOpLbu, 32'h101, 32'h0,         32'h1122_3344, 0, 4'b0010, 32'h0,         32'h0000_0033};
        tbl[1] = '{AluOpLh,  32'h102, 32'h0,         32'h8765_4321, 4, 4'b1100, 32'h0,         32'hFFFF_8765};
        tbl[2] = '{AluOpSb,  32'h103, 32'hAABB_CCDD, 32'h0,         0, 4'b1000, 32'hDDDD_DDDD, 32'h0};
        tbl[3] = '{AluOpLw,  32'h200, 32'h0,         32'hDEAD_BEEF, 1, 4'b1111, 32'h0,         32'hDEAD_BEEF};
        tbl[4] = '{AluOpLb,  32'h002, 32'h0,         32'h0080_0000, 0, 4'b0100, 32'h0,         32'hFFFF_FF80};
        tbl[5] = '{AluOpLhu, 32'h010, 32'h0,         32'h0000_F00F, 2, 4'b0011, 32'h0,         32'h0000_F00F};
        tbl[6] = '{AluOpSh,  32'h022, 32'h1234_5678, 32'h0,         0, 4'b1100, 32'h5678_5678, 32'h0};
        tbl[7] = '{AluOpSw,  32'h030, 32'hCAFE_BABE, 32'h0,         3, 4'b1111, 32'hCAFE_BABE, 32'h0};
        tbl[8] = '{AluOpLb,  32'h001, 32'h0,         32'h0000_7F00, 0, 4'b0010, 32'h0,         32'h0000_007F};
        tbl[9] = '{AluOpLhu, 32'h012, 32'h0,         32'hFFFE_0000, 0, 4'b1100, 32'h0,         32'h0000_FFFE};

        rst        = 1'b0;
        dbus_ack   = 1'b0;
        dbus_rdata = 32'h0;
        drive_nop();
        #1;
        chk("rst_wb_wreg", {31'b0, wb_wreg}, 32'h0);
        chk("rst_wb_wdata", wb_wdata, 32'h0);
        chk("rst_dbus_req", {31'b0, dbus_req}, 32'h0);
        chk("rst_dbus_sel", {28'b0, dbus_sel}, 32'h0);
        chk("rst_stall", {31'b0, stall_req}, 32'h0);
        chk("rst_exc_valid", {31'b0, exc_valid}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_alu(5'd3, 1'b1, 32'h1234_5678);
        run_alu(5'd17, 1'b0, 32'hFFFF_0001);

        for (int i = 0; i < 10; i++) begin
            run_mem(tbl[i].op, tbl[i].addr, tbl[i].reg2, tbl[i].rdata, tbl[i].waits, 1'b0,
                    tbl[i].sel, tbl[i].bw, tbl[i].wb);
        end

        // Ack held high through IDLE and DONE must only be taken in REQ.
        run_mem(AluOpLw, 32'h40, 32'h0, 32'h0102_0304, 0, 1'b1, 4'b1111, 32'h0, 32'h0102_0304);
        run_alu(5'd9, 1'b1, 32'h0BAD_F00D);

        // Reset in the middle of a bus request abandons the transaction.
        mem_aluop    = AluOpLw;
        mem_mem_addr = 32'h80;
        mem_wd       = 5'd4;
        mem_wreg     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstreq_req_up", {31'b0, dbus_req}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("rstreq_req_low", {31'b0, dbus_req}, 32'h0);
        chk("rstreq_stall_low", {31'b0, stall_req}, 32'h0);
        chk("rstreq_addr_low", dbus_addr, 32'h0);
        chk("rstreq_wb_wreg", {31'b0, wb_wreg}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        run_mem(AluOpLw, 32'h84, 32'h0, 32'h7654_3210, 1, 1'b0, 4'b1111, 32'h0, 32'h7654_3210);

`ifdef MEM_ALIGN_CHECK_EN
        mem_aluop    = AluOpLw;
        mem_mem_addr = 32'h106;
        mem_pc       = 32'h400;
        mem_wd       = 5'd6;
        mem_wreg     = 1'b1;
        #1;
        chk("adel_stall", {31'b0, stall_req}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("adel_no_req", {31'b0, dbus_req}, 32'h0);
        chk("adel_valid", {31'b0, exc_valid}, 32'h1);
        chk("adel_code", {27'b0, exc_code}, 32'd4);
        chk("adel_badvaddr", exc_badvaddr, 32'h106);
        chk("adel_pc", exc_pc, 32'h400);
        chk("adel_wb_wreg", {31'b0, wb_wreg}, 32'h0);
        mem_aluop    = AluOpSh;
        mem_mem_addr = 32'h201;
        mem_pc       = 32'h404;
        @(posedge clk);
        @(negedge clk);
        chk("ades_valid", {31'b0, exc_valid}, 32'h1);
        chk("ades_code", {27'b0, exc_code}, 32'd5);
        chk("ades_badvaddr", exc_badvaddr, 32'h201);
        chk("ades_no_req", {31'b0, dbus_req}, 32'h0);
        drive_nop();
        @(posedge clk);
        @(negedge clk);
        chk("exc_one_cycle", {31'b0, exc_valid}, 32'h0);
`else
        run_mem(AluOpLw, 32'h106, 32'h0, 32'hA1B2_C3D4, 0, 1'b0, 4'b1111, 32'h0, 32'hA1B2_C3D4);
        run_mem(AluOpLh, 32'h101, 32'h0, 32'hA1B2_C3D4, 0, 1'b0, 4'b0011, 32'h0, 32'hFFFF_C3D4);
        run_mem(AluOpSw, 32'h10B, 32'h1357_9BDF, 32'h0, 1, 1'b0, 4'b1111, 32'h1357_9BDF, 32'h0);
`endif

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                run_alu(5'($urandom), 1'($urandom), $urandom);
            end else begin
                logic [7:0]  op;
                logic [31:0] addr;
                logic [31:0] reg2;
                logic [31:0] rdata;
                int unsigned n;
                case ($urandom_range(0, 7))
                    0:       op = AluOpLb;
                    1:       op = AluOpLbu;
                    2:       op = AluOpLh;
                    3:       op = AluOpLhu;
                    4:       op = AluOpLw;
                    5:       op = AluOpSb;
                    6:       op = AluOpSh;
                    default: op = AluOpSw;
                endcase
                n     = size_bytes(op);
                addr  = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 3) / n) * n);
                reg2  = $urandom;
                rdata = $urandom;
                run_mem(op, addr, reg2, rdata, $urandom_range(0, 3), 1'b0, m_sel(op, addr),
                        m_wdata(op, reg2), m_load(op, addr, rdata));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
